// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: round-robin arbiter sharing one N-bit 8:1 datapath mux
// between eight requesters. It grants one source at a time for a burst of up to
// MAX_BURST beats and forwards that source's data downstream with valid/ready.

// Plain 8:1 datapath mux built as an AND-OR tree of decoded slices.
module mux_8NtoN #(
  parameter int N = 24
) (
  input  logic           rst,     // active-low; forces the output to zero
  input  logic           en,      // 0 forces the output to zero
  input  logic [2:0]     sel,
  input  logic [8*N-1:0] data_i,
  output logic [N-1:0]   data_o
);

  logic [7:0]   slice_hit;
  logic [N-1:0] slice_masked [8];

  // Decode the select and mask each input slice with its own decode line.
  for (genvar gi = 0; gi < 8; gi++) begin : g_slice
    assign slice_hit[gi]    = rst && en && (sel == 3'(gi));
    assign slice_masked[gi] = data_i[gi*N +: N] & {N{slice_hit[gi]}};
  end

  // OR the masked slices together; only the decoded slice is non-zero.
  always_comb begin
    data_o = '0;
    for (int k = 0; k < 8; k++) begin
      data_o = data_o | slice_masked[k];
    end
  end

endmodule

module mux8_rr_arbiter #(
  parameter int N         = 24,
  parameter int MAX_BURST = 4
) (
  input  logic           clk,
  input  logic           rst,        // asynchronous, active-low
  input  logic           en,
  input  logic [7:0]     req,
  input  logic [8*N-1:0] data_i,
  input  logic           out_ready,
  output logic [7:0]     gnt,
  output logic [7:0]     ack,
  output logic [2:0]     sel,
  output logic           out_valid,
  output logic [N-1:0]   out_data,
  output logic           busy
);

  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t        state_reg;
  logic [2:0]    ptr_reg;
  logic [2:0]    sel_reg;
  logic [7:0]    gnt_reg;
  logic [CW-1:0] beat_cnt_reg;

  logic          winner_found;
  logic [2:0]    winner;
  logic [2:0]    scan_idx;
  logic          handshake;
  logic [CW-1:0] beat_cnt_inc;
  logic          last_beat;

  // Round-robin search: the lowest offset from ptr with a request wins.
  // Scanning from the far end down lets the nearest hit overwrite the rest.
  always_comb begin
    winner_found = 1'b0;
    winner       = '0;
    scan_idx     = '0;
    for (int k = 7; k >= 0; k--) begin
      scan_idx = ptr_reg + 3'(k);
      if (req[scan_idx]) begin
        winner       = scan_idx;
        winner_found = 1'b1;
      end
    end
  end

  // Beat bookkeeping for the granted source; valid only follows the live
  // request of the owner so a withdrawal drops out_valid in the same cycle.
  always_comb begin
    out_valid    = (state_reg == XFER) && req[sel_reg];
    handshake    = out_valid && out_ready;
    beat_cnt_inc = beat_cnt_reg + CW'(1);
    last_beat    = (beat_cnt_inc == CW'(MAX_BURST));
    ack          = handshake ? (8'b1 << sel_reg) : 8'h00;
  end

  // Arbitration FSM with registered grant, select and burst counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      ptr_reg      <= '0;
      sel_reg      <= '0;
      gnt_reg      <= '0;
      beat_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (en && winner_found) begin
            sel_reg      <= winner;
            gnt_reg      <= 8'b1 << winner;
            beat_cnt_reg <= '0;
            state_reg    <= XFER;
          end else begin
            gnt_reg <= '0;
          end
        end
        XFER: begin
          // Release on the last burst beat, on a beat accepted with en low,
          // or when the owner withdraws without a handshake. Otherwise hold.
          if ((handshake && (last_beat || !en)) || (!handshake && !req[sel_reg])) begin
            state_reg    <= IDLE;
            gnt_reg      <= '0;
            ptr_reg      <= sel_reg + 3'd1;
            beat_cnt_reg <= '0;
          end else if (handshake) begin
            beat_cnt_reg <= beat_cnt_inc;
          end
        end
        default: begin
          state_reg    <= IDLE;
          gnt_reg      <= '0;
          beat_cnt_reg <= '0;
        end
      endcase
    end
  end

  assign gnt  = gnt_reg;
  assign sel  = sel_reg;
  assign busy = (state_reg == XFER);

  // Shared datapath mux, permanently enabled and out of reset; the data path
  // simply follows the registered select.
  mux_8NtoN #(.N(N)) u_mux (
    .rst    (1'b1),
    .en     (1'b1),
    .sel    (sel_reg),
    .data_i (data_i),
    .data_o (out_data)
  );

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter: a table of per-cycle vectors plus
// hand-written sequences for async reset mid-burst and the all-request sweep.
module tb_mux8_rr_arbiter;

  localparam int N = 24;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic [7:0]     req;
  logic [8*N-1:0] data_i;
  logic           out_ready;
  logic [7:0]     gnt;
  logic [7:0]     ack;
  logic [2:0]     sel;
  logic           out_valid;
  logic [N-1:0]   out_data;
  logic           busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mux8_rr_arbiter #(.N(N), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .data_i    (data_i),
    .out_ready (out_ready),
    .gnt       (gnt),
    .ack       (ack),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy)
  );

  typedef struct {
    logic       en;
    logic [7:0] req;
    logic       rdy;
    logic [7:0] e_gnt;
    logic [2:0] e_sel;
    logic       e_valid;
    logic [7:0] e_ack;
    logic       e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [N-1:0] dval(input int i);
    return 24'h5A0000 + 24'(i) * 24'h010203;
  endfunction

  task automatic add(input logic e, input logic [7:0] r, input logic rd,
                     input logic [7:0] g, input logic [2:0] s, input logic v,
                     input logic [7:0] a, input logic b);
    vec_t t;
    t.en = e; t.req = r; t.rdy = rd; t.e_gnt = g; t.e_sel = s;
    t.e_valid = v; t.e_ack = a; t.e_busy = b;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] g, input logic [2:0] s,
                           input logic v, input logic [7:0] a, input logic b);
    chk({tag, " gnt"},       32'(gnt),       32'(g));
    chk({tag, " sel"},       32'(sel),       32'(s));
    chk({tag, " out_valid"}, 32'(out_valid), 32'(v));
    chk({tag, " ack"},       32'(ack),       32'(a));
    chk({tag, " busy"},      32'(busy),      32'(b));
    chk({tag, " out_data"},  32'(out_data),  32'(dval(int'(s))));
    $display("%s: req=%02h rdy=%0b en=%0b gnt=%02h sel=%0d valid=%0b ack=%02h busy=%0b data=%06h",
             tag, req, out_ready, en, gnt, sel, out_valid, ack, busy, out_data);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) data_i[i*N +: N] = dval(i);
    rst = 1'b0; en = 1'b1; req = 8'h00; out_ready = 1'b0;

    //   en  req    rdy  gnt    sel valid ack    busy
    // idle with no requests
    for (int i = 0; i < 5; i++) add(1, 8'h00, 1, 8'h00, 0, 0, 8'h00, 0);
    // single source 2: full burst of four, one dead cycle, re-grant
    add(1, 8'h04, 1, 8'h00, 0, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) add(1, 8'h04, 1, 8'h04, 2, 1, 8'h04, 1);
    add(1, 8'h04, 1, 8'h00, 2, 0, 8'h00, 0);
    add(1, 8'h04, 1, 8'h04, 2, 1, 8'h04, 1);
    add(1, 8'h00, 1, 8'h04, 2, 0, 8'h00, 1);
    add(1, 8'h00, 1, 8'h00, 2, 0, 8'h00, 0);
    // source 5 stalled by out_ready=0 for six cycles, then one beat
    add(1, 8'h20, 0, 8'h00, 2, 0, 8'h00, 0);
    for (int i = 0; i < 6; i++) add(1, 8'h20, 0, 8'h20, 5, 1, 8'h00, 1);
    add(1, 8'h20, 1, 8'h20, 5, 1, 8'h20, 1);
    add(1, 8'h00, 1, 8'h20, 5, 0, 8'h00, 1);
    add(1, 8'h00, 1, 8'h00, 5, 0, 8'h00, 0);
    // source 3 withdraws before any handshake; next scan starts at 4
    add(1, 8'h08, 0, 8'h00, 5, 0, 8'h00, 0);
    add(1, 8'h00, 0, 8'h08, 3, 0, 8'h00, 1);
    add(1, 8'h09, 0, 8'h00, 3, 0, 8'h00, 0);
    add(1, 8'h09, 0, 8'h01, 0, 1, 8'h00, 1);
    add(1, 8'h00, 0, 8'h01, 0, 0, 8'h00, 1);
    add(1, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0);
    // source 1: en drops on beat two, release, no grant while en=0
    add(1, 8'h02, 1, 8'h00, 0, 0, 8'h00, 0);
    add(1, 8'h02, 1, 8'h02, 1, 1, 8'h02, 1);
    add(0, 8'h02, 1, 8'h02, 1, 1, 8'h02, 1);
    add(0, 8'h02, 1, 8'h00, 1, 0, 8'h00, 0);
    add(0, 8'h02, 1, 8'h00, 1, 0, 8'h00, 0);
    add(1, 8'h02, 1, 8'h00, 1, 0, 8'h00, 0);
    // source 1 again, two beats accepted before the reset sequence
    add(1, 8'h02, 1, 8'h02, 1, 1, 8'h02, 1);
    add(1, 8'h02, 1, 8'h02, 1, 1, 8'h02, 1);

    // reset state
    repeat (2) @(negedge clk);
    #1 check_all("reset", 8'h00, 0, 0, 8'h00, 0);
    rst = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      en = vecs[i].en; req = vecs[i].req; out_ready = vecs[i].rdy;
      #1 check_all($sformatf("vec%0d", i), vecs[i].e_gnt, vecs[i].e_sel,
                   vecs[i].e_valid, vecs[i].e_ack, vecs[i].e_busy);
    end

    // async reset mid-burst: outputs drop immediately, ptr returns to 0
    @(negedge clk);
    rst = 1'b0;
    #1 check_all("midrst", 8'h00, 0, 0, 8'h00, 0);
    @(negedge clk);
    rst = 1'b1; req = 8'h06; out_ready = 1'b1; en = 1'b1;
    #1 check_all("postrst_idle", 8'h00, 0, 0, 8'h00, 0);
    @(negedge clk);
    #1 check_all("postrst_gnt", 8'h02, 1, 1, 8'h02, 1);
    @(negedge clk);
    req = 8'h00;
    #1 check_all("postrst_drop", 8'h02, 1, 0, 8'h00, 1);

    // all sources requesting: grants 0..7 then 0, four beats each, one gap
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1; req = 8'hFF; out_ready = 1'b1;
    #1 check_all("rr_start", 8'h00, 0, 0, 8'h00, 0);
    for (int g = 0; g < 9; g++) begin
      logic [2:0] w;
      w = 3'(g % 8);
      for (int b = 0; b < 4; b++) begin
        @(negedge clk);
        #1 check_all($sformatf("rr_g%0d_b%0d", g, b), 8'b1 << w, w, 1, 8'b1 << w, 1);
      end
      @(negedge clk);
      #1 check_all($sformatf("rr_g%0d_gap", g), 8'h00, w, 0, 8'h00, 0);
    end
    req = 8'h00;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
- Round-robin arbiter sharing one N-bit 8:1 datapath mux (mux_8NtoN) between 8 requesters.
- Owns the mux select. Drives one-hot grants and per-beat acks.
- Presents the selected requester's data downstream with a valid/ready handshake.
- Holds a grant for bursts of up to MAX_BURST beats.

Parameters:
- N, 24, data width of each requester and of out_data.
- MAX_BURST, 4, maximum accepted beats per grant (≥1); the burst counter is $clog2(MAX_BURST+1) bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  arbitration enable; 0 blocks new grants.
- req  input  8  request per requester; held high while it has data.
- data_i  input  8*N  packed requester data; requester i in bits [i*N +: N].
- out_ready  input  1  downstream accepts the current beat.
- gnt  output  8  one-hot grant, registered.
- ack  output  8  one-hot, 1-cycle beat-accepted pulse to the granted requester.
- sel  output  3  mux select, registered; equals the index of the gnt bit.
- out_valid  output  1  beat valid downstream.
- out_data  output  N  data_i slice of requester sel, through the mux_8NtoN instance (en tied 1, its reset inactive).
- busy  output  1  1 while in XFER.

Behaviour:
- Reset (rst=0, async): state=IDLE, ptr=0, sel=0, gnt=0, beat_cnt=0. Outputs out_valid=0, ack=0, busy=0. out_data follows data_i[0]. Reset mid-burst drops the burst with no ack.
- State IDLE:
  - If en=1 and req≠0: winner = first set bit of req scanning ptr, ptr+1, … ptr+7 (mod 8).
  - Next edge: sel←winner, gnt←1<<winner, beat_cnt←0, state→XFER.
  - Otherwise stay in IDLE, gnt=0.
- State XFER:
  - out_valid = req[sel] (combinational); busy=1.
  - A handshake is out_valid & out_ready. In the handshake cycle, ack[sel]=1 combinationally and the requester must update or drop its data/req by the next edge.
  - On handshake: beat_cnt+1. Release if beat_cnt+1==MAX_BURST, or en=0; otherwise stay in XFER.
  - No handshake and req[sel]=0 (requester withdrew): release without ack.
  - No handshake and req[sel]=1: hold. sel, gnt and out_data are stable; no timeout.
- Release, next edge: state→IDLE, gnt←0, ptr←(sel+1) mod 8, beat_cnt←0; sel keeps its last value.
- Latency and gaps:
  - req rise in IDLE → gnt/out_valid 1 cycle later.
  - After a release there is one dead IDLE cycle before the next grant, including when the same requester wins again.
  - Peak throughput: MAX_BURST beats per MAX_BURST+1 cycles.
- Fairness: ptr moves past the last winner, so each continuously requesting source wins within 8 grants.
- en=0 in IDLE blocks grants. en=0 in XFER lets the current beat finish; release happens at that beat's handshake.
- ack is never asserted outside XFER; at most one ack and one gnt bit are set at a time.
- Simultaneous events:
  - Handshake and the final burst beat in the same cycle: a single release.
  - req of other sources changing during XFER: ignored until IDLE.

Test Plan:
- Reset then req=8'h00 for 5 cycles → gnt=0, out_valid=0, ack=0, state IDLE throughout.
- req=8'b0000_0100 held, out_ready=1, MAX_BURST=4:
  - gnt=8'h04 and sel=2 one cycle after req.
  - 4 consecutive ack[2] pulses, out_data = data_i[2] each beat.
  - Release, 1 IDLE cycle, re-grant to 2.
- req=8'hFF held, out_ready=1 → grant order 0,1,2,…,7,0; each grant lasts 4 beats; 1 idle cycle between grants.
- Granted to 5, out_ready=0 for 6 cycles → out_valid=1, out_data stable = data_i[5], ack=0. Then out_ready=1 → ack[5] pulse in that cycle.
- Granted to 3, req[3] drops before any handshake → out_valid falls the same cycle, release, ack never set, next grant scans from 4 (req=8'h09 → winner 0).
- Mid-burst on source 1 (beat 2 accepted):
  - en=0 with out_ready=1 → release after that beat's handshake; no grant while en=0.
  - Separately, rst=0 mid-burst → gnt=0, out_valid=0 immediately; ptr=0 afterwards.
